// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters
//               (port 0 = fetch/PC-update, port 1 = execute). Round-robin
//               arbitration with an optional bounded lock for back-to-back
//               operations, and a single registered response slot with
//               valid/ready backpressure.
// Ports       : clk, reset                   clock / sync active-high reset
//               reqN_valid/ready/lock        request handshake + lock hint
//               reqN_a/b/ctrl                request operands and ALU code
//               alu_a/b/ctrl                 operands driven to the ALU
//               alu_result/zero              ALU outputs
//               rsp_valid/ready              response slot handshake
//               rsp_id/result/zero           registered response contents
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH    = 32,
    parameter int CTRL_W   = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_lock,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_lock,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero
);

    localparam int                 c_cnt_w    = $clog2(MAX_LOCK + 1);
    localparam logic [c_cnt_w-1:0] c_max_lock = c_cnt_w'(MAX_LOCK);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_zero;
    logic               r_last_grant;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic               r_lock_owner;

    logic w_slot_free;
    logic w_owner_valid;
    logic w_other_valid;
    logic w_lock_hold;
    logic w_lock_yield;
    logic w_gnt;
    logic w_gnt_id;
    logic w_acc;
    logic w_acc_lock;

    assign w_slot_free   = !r_rsp_valid || rsp_ready;
    assign w_owner_valid = r_lock_owner ? req1_valid : req0_valid;
    assign w_other_valid = r_lock_owner ? req0_valid : req1_valid;

    // A non-zero count means the most recent accept asked to keep the grant.
    assign w_lock_hold  = (r_lock_cnt != '0) && w_owner_valid && (r_lock_cnt < c_max_lock);
    // Owner has used all its consecutive grants; a waiting peer must go next.
    assign w_lock_yield = (r_lock_cnt == c_max_lock) && w_other_valid;

    // Grant depends only on state and valids, so it stays put during a stall.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = 1'b0;
        if (w_lock_hold) begin
            w_gnt    = 1'b1;
            w_gnt_id = r_lock_owner;
        end else if (w_lock_yield) begin
            w_gnt    = 1'b1;
            w_gnt_id = !r_lock_owner;
        end else if (req0_valid && req1_valid) begin
            w_gnt    = 1'b1;
            w_gnt_id = !r_last_grant;
        end else if (req0_valid) begin
            w_gnt    = 1'b1;
            w_gnt_id = 1'b0;
        end else if (req1_valid) begin
            w_gnt    = 1'b1;
            w_gnt_id = 1'b1;
        end
    end

    assign req0_ready = !reset && w_gnt && !w_gnt_id && req0_valid && w_slot_free;
    assign req1_ready = !reset && w_gnt &&  w_gnt_id && req1_valid && w_slot_free;
    assign w_acc      = req0_ready || req1_ready;
    assign w_acc_lock = w_gnt_id ? req1_lock : req0_lock;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (w_gnt) begin
            alu_a    = w_gnt_id ? req1_a    : req0_a;
            alu_b    = w_gnt_id ? req1_b    : req0_b;
            alu_ctrl = w_gnt_id ? req1_ctrl : req0_ctrl;
        end
    end

    // Response slot: an accept reloads it even while it is being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_gnt_id;
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    // Arbitration history: last accepted port and lock run length.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
            r_lock_owner <= 1'b0;
        end else if (w_acc) begin
            r_last_grant <= w_gnt_id;
            if (w_acc_lock) begin
                if ((r_lock_cnt != '0) && (r_lock_owner == w_gnt_id)) begin
                    if (r_lock_cnt != c_max_lock) begin
                        r_lock_cnt <= r_lock_cnt + c_one;
                    end
                end else begin
                    r_lock_owner <= w_gnt_id;
                    r_lock_cnt   <= c_one;
                end
            end else begin
                r_lock_cnt <= '0;
            end
        end else if (!w_owner_valid) begin
            // Lock lapses as soon as its owner goes idle.
            r_lock_cnt <= '0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

endmodule
`default_nettype wire
